uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte-stream requesters sharing one uart transmitter (2..8).
REQ-002 Parameter ACK_TO, default 15, SHALL set the maximum cycles to wait for tx_busy to rise after tx_start (1..255).
REQ-003 Ports: clk  in  1  single system clock, all logic on rising edge.
REQ-004 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: req_valid  in  NREQ  per-requester byte available.
REQ-006 Ports: req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Ports: req_last  in  NREQ  byte is the final byte of its message.
REQ-008 Ports: req_ready  out  NREQ  byte accepted this cycle; one-hot or zero.
REQ-009 Ports: grant  out  NREQ  registered one-hot owner of the transmitter; zero when unlocked.
REQ-010 Ports: tx_start  out  1  one-cycle strobe to uart transmit input.
REQ-011 Ports: tx_data  out  8  registered byte to uart data input, stable from tx_start until the next accept.
REQ-012 Ports: tx_busy  in  1  uart transmitter busy.
REQ-013 Ports: ack_err  out  1  sticky flag: uart failed to acknowledge a tx_start.

Function
REQ-014 FSM states SHALL be IDLE, START, ACK, DRAIN.
REQ-015 IDLE, unlocked: if tx_busy=0 and any req_valid, select by round-robin starting at (last owner+1) mod NREQ; assert req_ready[sel] combinationally that cycle, capture req_data[sel] into tx_data, set grant to sel, go to START.
REQ-016 IDLE, locked: only the owner is eligible; other requesters SHALL NOT receive req_ready even if the owner's req_valid is low.
REQ-017 No accept SHALL occur in IDLE while tx_busy=1.
REQ-018 Lock SHALL set on accepting a byte with req_last=0 and clear on accepting a byte with req_last=1 (grant returns to zero on entering START for that byte; last-owner pointer updated).
REQ-019 START: tx_start=1 for exactly one cycle; clear ack counter; go to ACK.
REQ-020 ACK: if tx_busy=1 go to DRAIN; else increment counter; when counter reaches ACK_TO set ack_err and go to IDLE.
REQ-021 DRAIN: remain until tx_busy=0, then go to IDLE.
REQ-022 Latency: req_valid seen in IDLE at cycle N -> req_ready at N, tx_start at N+1.
REQ-023 Minimum spacing between accepts SHALL be 4 cycles (IDLE, START, ACK, DRAIN) given a 1-cycle busy pulse.
REQ-024 Last-owner pointer SHALL wrap from NREQ-1 to 0.
REQ-025 ack_err SHALL only clear by reset.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, grant=0, lock=0, last owner=NREQ-1 (so requester 0 wins first), tx_start=0, tx_data=8'h00, ack counter=0, ack_err=0; req_ready=0 during reset.
REQ-027 Reset mid-message SHALL drop the lock; the requester restarts its message after release.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and ACK_TO default; NREQ is a module parameter.
REQ-029 One sub-module, rr_pick, SHALL compute the round-robin one-hot selection from valid vector and last-owner pointer (combinational).

Verification
REQ-030 Reset release, req_valid=4'b0001, data 8'hAA, last=1, tx_busy pulse 10 cycles after start -> tx_start once, tx_data=8'hAA, grant 0 after, ack_err=0.
REQ-031 req_valid=4'b1111 all last=1, continuously -> accept order 0,1,2,3,0; each tx_start preceded by tx_busy low.
REQ-032 Requester 2 sends 3-byte message (last on third) while requester 1 valid throughout -> bytes 2,2,2 then 1; requester 1 never ready mid-message even when requester 2 idles 20 cycles.
REQ-033 tx_busy tied 0 -> after tx_start, ACK_TO=15 cycles later ack_err=1, FSM in IDLE, next request still served.
REQ-034 tx_busy held 1 before any request -> no req_ready until tx_busy falls.
REQ-035 rst_n asserted in DRAIN with lock held -> all outputs to reset values immediately, no tx_start after release until a new request.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
//
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e    : FSM state encoding (IDLE, START, ACK, DRAIN)
//   - ACK_TO_DEFAULT : default number of cycles to wait for tx_busy to rise
//   - ACK_CNT_W      : width of the acknowledge-timeout counter (ACK_TO <= 255)
//   - idx_width()    : width of an index into an NREQ-wide vector
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for an eligible requester and an idle uart
        ST_START = 2'd1,  // one-cycle tx_start strobe
        ST_ACK   = 2'd2,  // waiting for the uart to raise tx_busy
        ST_DRAIN = 2'd3   // waiting for the uart to finish the byte
    } arb_state_e;

    localparam int unsigned ACK_TO_DEFAULT = 15;
    localparam int unsigned ACK_CNT_W      = 8;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin selector. Starting at (last_idx + 1) mod NREQ and
// walking upward with wrap-around, the first set bit of 'valid' wins.
//
// Ports:
//   valid    in  NREQ   candidate requesters
//   last_idx in  IDX_W  index of the most recent owner
//   sel_oh   out NREQ   one-hot winner, zero when no candidate
//   sel_idx  out IDX_W  index of the winner (zero when none)
//   sel_any  out 1      at least one candidate present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last_idx,
    output logic [NREQ-1:0]  sel_oh,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_any
);

    logic [IDX_W-1:0] cand_idx;

    // NOTE: every output and temporary gets a default before the loop so
    // no path through this block leaves a value unassigned (no latches).
    always_comb begin
        sel_oh   = '0;
        sel_idx  = '0;
        sel_any  = 1'b0;
        cand_idx = '0;
        // Offset 1 is the requester just after the last owner, offset NREQ
        // is the last owner itself, so it only wins when nobody else asks.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_idx = IDX_W'((32'(last_idx) + k) % NREQ);
            if (!sel_any && valid[cand_idx]) begin
                sel_any          = 1'b1;
                sel_oh[cand_idx] = 1'b1;
                sel_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one uart transmitter between NREQ byte-stream requesters. A byte is
// accepted only while the FSM is idle and the uart is not busy; a byte with
// req_last=0 locks the transmitter to its requester until that requester's
// req_last=1 byte is accepted. Each accepted byte is launched with a one-cycle
// tx_start, after which the arbiter waits for the uart to raise tx_busy (up to
// ACK_TO cycles, else sticky ack_err) and then for tx_busy to fall.
//
// Ports:
//   clk        in  1       system clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   req_valid  in  NREQ    per-requester byte available
//   req_data   in  8*NREQ  requester i on bits [8i+7:8i]
//   req_last   in  NREQ    byte ends its message
//   req_ready  out NREQ    byte accepted this cycle (one-hot or zero)
//   grant      out NREQ    registered one-hot lock owner, zero when unlocked
//   tx_start   out 1       one-cycle strobe to the uart
//   tx_data    out 8       registered byte for the uart
//   tx_busy    in  1       uart busy
//   ack_err    out 1       sticky: uart failed to acknowledge a tx_start
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ACK_TO = ACK_TO_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              ack_err
);

    localparam int unsigned          IDX_W      = idx_width(NREQ);
    localparam logic [ACK_CNT_W-1:0] ACK_TO_CNT = ACK_CNT_W'(ACK_TO);

    arb_state_e           state_q,   state_d;
    logic [NREQ-1:0]      grant_q,   grant_d;
    logic [IDX_W-1:0]     last_q,    last_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic                 ack_err_q, ack_err_d;

    logic                 locked;
    logic [NREQ-1:0]      eligible;
    logic [NREQ-1:0]      sel_oh;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic [NREQ-1:0]      ready_c;

    // The lock is exactly "grant is non-zero": grant holds the owner from
    // the first byte of a message until its last byte is accepted.
    assign locked   = |grant_q;
    assign eligible = locked ? (req_valid & grant_q) : req_valid;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid    (eligible),
        .last_idx (last_q),
        .sel_oh   (sel_oh),
        .sel_idx  (sel_idx),
        .sel_any  (sel_any)
    );

    // Byte and last flag of the winner, muxed with the one-hot select.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_oh[i]) begin
                sel_data = sel_data | req_data[8*i +: 8];
                sel_last = sel_last | req_last[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        ack_cnt_d = ack_cnt_q;
        ack_err_d = ack_err_q;
        ready_c   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!tx_busy && sel_any) begin
                    ready_c   = sel_oh;
                    tx_data_d = sel_data;
                    last_d    = sel_idx;
                    // A final byte releases the lock as it is launched.
                    grant_d   = sel_last ? '0 : sel_oh;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                ack_cnt_d = '0;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                    if (ack_cnt_d == ACK_TO_CNT) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from the same pre-edge view of the design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            tx_data_q <= 8'h00;
            ack_cnt_q <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            ack_cnt_q <= ack_cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    // req_ready is combinational from the IDLE state, which the async reset
    // forces; gating with rst_n keeps it low for the whole reset window.
    assign req_ready = ready_c & {NREQ{rst_n}};
    assign grant     = grant_q;
    assign tx_start  = (state_q == ST_START);
    assign tx_data   = tx_data_q;
    assign ack_err   = ack_err_q;

endmodule
